// File: rtl/pulse_sched.sv
// Round-robin scheduler that shares one DMA pulse stretcher among NREQ channels.
// It grants one channel, tracks the pulse to its end, then holds off for a guard gap.
module pulse_sched #(
  parameter int NREQ  = 4,
  parameter int GAP_W = 4,
  parameter int TMO   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NREQ-1:0]              req,
  input  logic [6*NREQ-1:0]            interval_in,
  input  logic [GAP_W-1:0]             gap,
  input  logic                         pulse,
  output logic                         trig,
  output logic [5:0]                   interval,
  output logic [NREQ-1:0]              ack,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic                         busy,
  output logic                         err
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_END, GAP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   sel;
  logic             found;
  logic             do_grant;
  logic             set_err;
  logic [5:0]       sel_interval;
  logic [GAP_W-1:0] gap_cnt;
  logic [TW-1:0]    tmo_cnt;

  // Search starts just after the last winner so every channel gets a turn.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  assign sel_interval = interval_in[int'(sel)*6 +: 6];

  always_comb begin
    state_nx = state;
    do_grant = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          do_grant = 1'b1;
          if (sel_interval != 6'd0)
            state_nx = WAIT_START;
          else if (gap != '0)
            state_nx = GAP;
          else
            state_nx = IDLE;
        end
      end
      WAIT_START: begin
        if (pulse) begin
          state_nx = WAIT_END;
        end else if (tmo_cnt == TW'(TMO - 1)) begin
          set_err  = 1'b1;
          state_nx = (gap_cnt != '0) ? GAP : IDLE;
        end
      end
      WAIT_END: begin
        if (!pulse)
          state_nx = (gap_cnt != '0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // gap_cnt holds the gap sampled at grant until GAP starts counting it down.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      trig     <= 1'b0;
      ack      <= '0;
      interval <= 6'd0;
      grant_id <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ptr      <= IDW'(NREQ - 1);
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      trig  <= do_grant;
      ack   <= do_grant ? (NREQ'(1) << sel) : '0;
      if (do_grant) begin
        interval <= sel_interval;
        grant_id <= sel;
        ptr      <= sel;
        gap_cnt  <= gap;
        tmo_cnt  <= '0;
      end else begin
        if (state == GAP)
          gap_cnt <= gap_cnt - GAP_W'(1);
        if (state == WAIT_START)
          tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (set_err)
        err <= 1'b1;
    end
  end

endmodule

// File: doc/pulse_sched.md
Name: pulse_sched

Overview:
- Scheduler that lets NREQ DMA channels share one DMA pulse stretcher.
- Arbitrates requests round-robin and issues a one-cycle trig plus the winner's 6-bit interval to the stretcher.
- Tracks the resulting pulse to completion, then enforces a programmable guard gap before the next grant.
- Sits between the per-channel DMA sequencers and the stretcher.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_W, 4, width of guard-gap count
TMO, 4, cycles to wait for pulse rise after trig before flagging error

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
enable  in  1  allow new grants; low = finish current pulse, then hold in IDLE
req  in  NREQ  per-channel request; level, held until ack
interval_in  in  6*NREQ  channel i interval at bits [6i+5:6i]
gap  in  GAP_W  guard cycles after pulse end; sampled at grant
pulse  in  1  stretcher output
trig  out  1  one-cycle trigger to stretcher
interval  out  6  interval to stretcher, valid while trig=1, held until next grant
ack  out  NREQ  one-hot, one-cycle grant acknowledge
grant_id  out  clog2(NREQ)  index of last granted channel
busy  out  1  high whenever state != IDLE
err  out  1  sticky; set on pulse-start timeout

Behaviour:
- Stretcher contract: pulse rises exactly 2 cycles after trig, stays high for interval cycles, no pulse when interval=0.
- Reset: state IDLE; trig=0, interval=0, ack=0, grant_id=0, busy=0, err=0; rr pointer = NREQ-1, so channel 0 has first priority. Reset mid-operation aborts immediately; no ack or trig is issued.
- All outputs registered.
- IDLE: if enable && |req, select the first set req starting at (ptr+1) mod NREQ and wrapping. At the clock edge:
  - trig=1, ack[sel]=1, interval=interval_in[sel], grant_id=sel, ptr=sel; latch gap.
  - Next state: GAP if interval_in[sel]==0 (and gap!=0), IDLE if both are 0, otherwise WAIT_START.
  - trig/ack drop the following cycle.
- WAIT_START: wait for pulse=1, then go to WAIT_END. If pulse stays low for TMO cycles counted from the trig cycle, set err and go to GAP (or IDLE if gap=0).
- WAIT_END: on the first cycle pulse=0, go to GAP (gap>0) or IDLE (gap=0).
- GAP: exactly gap cycles, then IDLE.
- Spacing: if pulse is first seen low in cycle c, the next trig occurs no earlier than cycle c+gap+2.
- Pulse activity in IDLE or GAP is ignored.
- enable is checked only in IDLE; deasserting it never truncates a pulse.
- A req dropped before ack is simply not considered. A req held after ack is treated as a new request, arbitrated round-robin behind the other channels.
- Simultaneous requests: exactly one ack per grant; no channel waits more than NREQ-1 grants.
- err is cleared only by rst.

Test Plan:
- Single request, gap=2: req[0]=1 with interval 3 → ack[0] and trig high in the same cycle t, interval=3; pulse high t+2..t+4; busy high from t through the gap; next trig no earlier than t+9.
- Fairness: req=4'b1111 held, each channel re-raising req after its ack → ack order 0,1,2,3,0; grant_id follows that order.
- Zero interval: req[2] with interval 0, gap=0 → trig/ack for one cycle, state returns to IDLE the next cycle, err stays 0.
- Timeout: stretcher stubbed to hold pulse=0 → err=1 four cycles after trig; scheduler recovers and serves the next request.
- enable dropped during WAIT_END → current pulse completes and busy falls; no further ack while enable=0; grants resume the cycle after enable returns.
- rst asserted in WAIT_END → next cycle all outputs are 0; after release, channel 0 wins the first grant.
